// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extender for the MIPS decode stage.
// Supports sign, zero, upper (LUI) and branch-offset (sign-extend << 2) modes.
// Results sit in a main register M with a one-entry skid register S behind it,
// so decode can stall without losing an immediate. A tag travels with each result.
// Optional: define IMMX_COUNT_EN to add a 32-bit xfer_count port that counts
// output handshakes.

module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMX_COUNT_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_t;

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic             s_valid;
  logic [OUT_W-1:0] s_data;
  logic [TAG_W-1:0] s_tag;
  logic             in_ready_q;

  logic             accept;
  logic             out_hs;
  logic             s_valid_next;

  // Extension happens before storage so both M and S hold finished results.
  always_comb begin
    sext     = {{EXT_W{in_data[IN_W-1]}}, in_data};
    zext     = {{EXT_W{1'b0}}, in_data};
    ext_data = sext;
    case (mode_t'(in_mode))
      MODE_SIGN:   ext_data = sext;
      MODE_ZERO:   ext_data = zext;
      MODE_UPPER:  ext_data = zext << EXT_W;
      MODE_BRANCH: ext_data = sext << 2;
      default:     ext_data = sext;
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign out_hs = m_valid & out_ready;

  // Next occupancy of S: fills on an accept that M cannot absorb, drains on a handshake.
  always_comb begin
    s_valid_next = s_valid;
    if (accept) begin
      if (m_valid && !out_ready) begin
        s_valid_next = 1'b1;
      end
    end else if (out_hs) begin
      s_valid_next = 1'b0;
    end
  end

  // M/S storage: new beats go to M when it is free or leaving, else spill into S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_tag      <= '0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_tag      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= !s_valid_next;
      s_valid    <= s_valid_next;
      if (accept) begin
        if (!m_valid || out_ready) begin
          m_valid <= 1'b1;
          m_data  <= ext_data;
          m_tag   <= in_tag;
        end else begin
          s_data <= ext_data;
          s_tag  <= in_tag;
        end
      end else if (out_hs) begin
        if (s_valid) begin
          m_data <= s_data;
          m_tag  <= s_tag;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_tag   = m_tag;

`ifdef IMMX_COUNT_EN
  logic [31:0] xfer_cnt;

  // Counts completed output handshakes, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_hs) begin
      xfer_cnt <= xfer_cnt + 32'd1;
    end
  end

  assign xfer_count = xfer_cnt;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed self-checking bench for imm_extend_pipe.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef IMMX_COUNT_EN
  logic [31:0] xfer_count;
`endif

  int testCount;
  int failCount;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef IMMX_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: data, mode, tag and the hand-computed extended result.
  logic [15:0] vecData [8];
  logic [1:0]  vecMode [8];
  logic [4:0]  vecTag  [8];
  logic [31:0] vecExp  [8];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [1:0] m, input logic [4:0] t);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 2'b00, 5'd0);

    vecData[0] = 16'hFFFF; vecMode[0] = 2'b00; vecTag[0] = 5'd1;  vecExp[0] = 32'hFFFFFFFF;
    vecData[1] = 16'h000F; vecMode[1] = 2'b00; vecTag[1] = 5'd2;  vecExp[1] = 32'h0000000F;
    vecData[2] = 16'h8000; vecMode[2] = 2'b01; vecTag[2] = 5'd3;  vecExp[2] = 32'h00008000;
    vecData[3] = 16'h1234; vecMode[3] = 2'b10; vecTag[3] = 5'd7;  vecExp[3] = 32'h12340000;
    vecData[4] = 16'hFFFF; vecMode[4] = 2'b11; vecTag[4] = 5'd9;  vecExp[4] = 32'hFFFFFFFC;
    vecData[5] = 16'h4000; vecMode[5] = 2'b11; vecTag[5] = 5'd10; vecExp[5] = 32'h00010000;
    vecData[6] = 16'h8000; vecMode[6] = 2'b00; vecTag[6] = 5'd11; vecExp[6] = 32'hFFFF8000;
    vecData[7] = 16'hFFFF; vecMode[7] = 2'b10; vecTag[7] = 5'd31; vecExp[7] = 32'hFFFF0000;

    // Reset values
    #1;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_data", {32'd0, out_data}, 64'd0);
    checkOutput("rst_out_tag", {59'd0, out_tag}, 64'd0);
`ifdef IMMX_COUNT_EN
    checkOutput("rst_count", {32'd0, xfer_count}, 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream with out_ready=1: each result one cycle after its accept
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecData[i], vecMode[i], vecTag[i]);
      @(negedge clk);
      checkOutput($sformatf("stream%0d_valid", i), {63'd0, out_valid}, 64'd1);
      checkOutput($sformatf("stream%0d_data", i), {32'd0, out_data}, {32'd0, vecExp[i]});
      checkOutput($sformatf("stream%0d_tag", i), {59'd0, out_tag}, {59'd0, vecTag[i]});
      checkOutput($sformatf("stream%0d_ready", i), {63'd0, in_ready}, 64'd1);
    end
    applyStimulus(1'b0, 16'hAAAA, 2'b00, 5'd0);
    @(negedge clk);
    checkOutput("stream_drain_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: A and B accepted, C held off until S drains
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0001, 2'b00, 5'd12);
    @(negedge clk);
    checkOutput("bp_ready_after_A", {63'd0, in_ready}, 64'd1);
    applyStimulus(1'b1, 16'h0002, 2'b00, 5'd13);
    @(negedge clk);
    checkOutput("bp_ready_after_B", {63'd0, in_ready}, 64'd0);
    applyStimulus(1'b1, 16'h0003, 2'b00, 5'd14);
    @(negedge clk);
    checkOutput("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_hold_data", {32'd0, out_data}, 64'h1);
    checkOutput("bp_hold_tag", {59'd0, out_tag}, 64'd12);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_B_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp_B_data", {32'd0, out_data}, 64'h2);
    checkOutput("bp_B_tag", {59'd0, out_tag}, 64'd13);
    checkOutput("bp_ready_reopen", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h5555, 2'b11, 5'd0);
    checkOutput("bp_C_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp_C_data", {32'd0, out_data}, 64'h3);
    checkOutput("bp_C_tag", {59'd0, out_tag}, 64'd14);
    @(negedge clk);
    checkOutput("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream with M and S both full
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h1111, 2'b01, 5'd20);
    @(negedge clk);
    applyStimulus(1'b1, 16'h2222, 2'b01, 5'd21);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 2'b00, 5'd0);
    checkOutput("mid_full_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_ready", {63'd0, in_ready}, 64'd1);
`ifdef IMMX_COUNT_EN
    checkOutput("mid_rst_count", {32'd0, xfer_count}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 16'h8001, 2'b00, 5'd22);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 2'b00, 5'd0);
    checkOutput("post_rst_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("post_rst_data", {32'd0, out_data}, 64'hFFFF8001);
    checkOutput("post_rst_tag", {59'd0, out_tag}, 64'd22);
    @(negedge clk);
    checkOutput("post_rst_drain", {63'd0, out_valid}, 64'd0);

`ifdef IMMX_COUNT_EN
    // Ten more handshakes after the one since reset
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'(i), 2'b01, 5'(i));
      @(negedge clk);
    end
    applyStimulus(1'b0, 16'h0, 2'b00, 5'd0);
    @(negedge clk);
    checkOutput("count_eleven", {32'd0, xfer_count}, 64'd11);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
